// File: rtl/br_resolve_ctrl_if.sv
// Branch-resolve control bus: branch-logic stage inputs, fetch/predictor handshakes,
// and the pipeline-control outputs of br_resolve_ctrl.
interface br_resolve_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              br_val;
    logic              br_taken;
    logic              br_correct;
    logic [ADDR_W-1:0] br_ip;
    logic [ADDR_W-1:0] br_nip;
    logic [ADDR_W-1:0] br_fip;
    logic              fe_ack;
    logic              bp_rdy;

    logic              stall;
    logic              flush;
    logic              redir_val;
    logic [ADDR_W-1:0] redir_ip;
    logic              bp_upd_val;
    logic [ADDR_W-1:0] bp_upd_ip;
    logic [ADDR_W-1:0] bp_upd_target;
    logic              bp_upd_taken;
    logic [15:0]       mispred_cnt;

    // master: the environment (branch stage, fetch, predictor); slave: the controller
    modport master (
        output br_val, br_taken, br_correct, br_ip, br_nip, br_fip, fe_ack, bp_rdy,
        input  stall, flush, redir_val, redir_ip, bp_upd_val, bp_upd_ip,
               bp_upd_target, bp_upd_taken, mispred_cnt
    );

    modport slave (
        input  br_val, br_taken, br_correct, br_ip, br_nip, br_fip, fe_ack, bp_rdy,
        output stall, flush, redir_val, redir_ip, bp_upd_val, bp_upd_ip,
               bp_upd_target, bp_upd_taken, mispred_cnt
    );
endinterface

// File: rtl/br_resolve_ctrl.sv
// Branch resolution controller: on a resolved branch, flushes and redirects fetch on a
// mispredict, then trains the predictor; stalls the EX-stage branch until done.
module br_resolve_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int FLUSH_CYC = 2,   // legal 1..15
    parameter int CNT_W     = 16   // mispredict counter width, 1..16, zero-extended onto the 16-bit port
) (
    input  logic               clk,
    input  logic               clr,
    br_resolve_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_REDIR = 2'd2,
        S_UPD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_nxt;
    logic [3:0]        r_fcnt;
    logic [ADDR_W-1:0] r_ip;
    logic [ADDR_W-1:0] r_fip;
    logic [ADDR_W-1:0] r_tgt;
    logic              r_taken;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_cap;
    logic              w_mis;

    // br_val only matters in IDLE; everywhere else the branch is held by stall
    assign w_cap = (r_state == S_IDLE) && bus.br_val;
    assign w_mis = w_cap && !bus.br_correct;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.br_val) begin
                    w_nxt = bus.br_correct ? S_UPD : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_fcnt == 4'd1) begin
                    w_nxt = S_REDIR;
                end
            end
            S_REDIR: begin
                if (bus.fe_ack) begin
                    w_nxt = S_UPD;
                end
            end
            S_UPD: begin
                if (bus.bp_rdy) begin
                    w_nxt = S_IDLE;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ip    <= '0;
            r_fip   <= '0;
            r_tgt   <= '0;
            r_taken <= 1'b0;
        end else if (w_cap) begin
            r_ip    <= bus.br_ip;
            r_fip   <= bus.br_fip;
            r_taken <= bus.br_taken;
            r_tgt   <= bus.br_taken ? bus.br_fip : bus.br_nip;
        end
    end

    // Flush length counter: loaded on the mispredict, leaves FLUSH when it reads 1
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_fcnt <= 4'd0;
        end else if (w_mis) begin
            r_fcnt <= 4'(FLUSH_CYC);
        end else if (r_state == S_FLUSH) begin
            r_fcnt <= r_fcnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt <= '0;
        end else if (w_mis && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.stall         = (r_state != S_IDLE);
    assign bus.flush         = (r_state == S_FLUSH);
    assign bus.redir_val     = (r_state == S_REDIR);
    assign bus.bp_upd_val    = (r_state == S_UPD);
    assign bus.redir_ip      = r_tgt;
    assign bus.bp_upd_ip     = r_ip;
    assign bus.bp_upd_target = r_fip;
    assign bus.bp_upd_taken  = r_taken;
    assign bus.mispred_cnt   = 16'(r_cnt);

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Bench for br_resolve_ctrl: transaction-level model compared every cycle, plus
// directed scenarios with literal expectations; a narrow-counter instance covers saturation.
module tb_br_resolve_ctrl;
    localparam int FC0 = 2;

    logic clk;
    logic clr;
    int   checks;
    int   errors;
    int   n_flush, n_redir, n_upd, n1_flush;

    br_resolve_ctrl_if #(.ADDR_W(32)) bif0 ();
    br_resolve_ctrl_if #(.ADDR_W(32)) bif1 ();

    br_resolve_ctrl #(.ADDR_W(32), .FLUSH_CYC(FC0), .CNT_W(16)) u0 (
        .clk (clk),
        .clr (clr),
        .bus (bif0)
    );

    br_resolve_ctrl #(.ADDR_W(32), .FLUSH_CYC(1), .CNT_W(4)) u1 (
        .clk (clk),
        .clr (clr),
        .bus (bif1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Model: a mispredict owes FLUSH_CYC flush cycles, then a redirect until acked,
    // then an update until accepted; a correct prediction owes only the update.
    int          m_flush_left;
    bit          m_redir, m_upd;
    logic [31:0] m_ip, m_fip, m_tgt;
    bit          m_taken;
    int          m_cnt;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_flush_left <= 0; m_redir <= 0; m_upd <= 0;
            m_ip <= 0; m_fip <= 0; m_tgt <= 0; m_taken <= 0; m_cnt <= 0;
        end else if (m_flush_left == 0 && !m_redir && !m_upd) begin
            if (bif0.br_val) begin
                m_ip    <= bif0.br_ip;
                m_fip   <= bif0.br_fip;
                m_taken <= bif0.br_taken;
                m_tgt   <= bif0.br_taken ? bif0.br_fip : bif0.br_nip;
                if (bif0.br_correct) m_upd <= 1;
                else begin
                    m_flush_left <= FC0;
                    m_cnt <= (m_cnt == 65535) ? m_cnt : m_cnt + 1;
                end
            end
        end else if (m_flush_left > 0) begin
            m_flush_left <= m_flush_left - 1;
            if (m_flush_left == 1) m_redir <= 1;
        end else if (m_redir) begin
            if (bif0.fe_ack) begin m_redir <= 0; m_upd <= 1; end
        end else if (bif0.bp_rdy) begin
            m_upd <= 0;
        end
    end

    always @(negedge clk) begin
        chk("stall", bif0.stall, (m_flush_left > 0) || m_redir || m_upd);
        chk("flush", bif0.flush, m_flush_left > 0);
        chk("redir_val", bif0.redir_val, m_redir);
        chk("bp_upd_val", bif0.bp_upd_val, m_upd);
        chk("mispred_cnt", bif0.mispred_cnt, m_cnt);
        if (m_redir) chk("redir_ip", bif0.redir_ip, m_tgt);
        if (m_upd) begin
            chk("bp_upd_ip", bif0.bp_upd_ip, m_ip);
            chk("bp_upd_target", bif0.bp_upd_target, m_fip);
            chk("bp_upd_taken", bif0.bp_upd_taken, m_taken);
        end
        if (bif0.flush) n_flush++;
        if (bif0.redir_val) n_redir++;
        if (bif0.bp_upd_val) n_upd++;
        if (bif1.flush) n1_flush++;
    end

    task automatic issue(input logic [31:0] ip, nip, fip, input bit tk, cor);
        @(negedge clk);
        bif0.br_val = 1; bif0.br_ip = ip; bif0.br_nip = nip; bif0.br_fip = fip;
        bif0.br_taken = tk; bif0.br_correct = cor;
        @(negedge clk);
        bif0.br_val = 0;
    endtask

    task automatic wait_redir();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bif0.redir_val) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("redir_seen", ok, 1);
    endtask

    task automatic clr_counts();
        n_flush = 0; n_redir = 0; n_upd = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; n1_flush = 0;
        clr_counts();
        clr = 0;
        bif0.br_val = 0; bif0.br_taken = 0; bif0.br_correct = 0;
        bif0.br_ip = 0; bif0.br_nip = 0; bif0.br_fip = 0;
        bif0.fe_ack = 0; bif0.bp_rdy = 1;
        bif1.br_val = 0; bif1.br_taken = 1; bif1.br_correct = 0;
        bif1.br_ip = 32'h100; bif1.br_nip = 32'h104; bif1.br_fip = 32'h200;
        bif1.fe_ack = 1; bif1.bp_rdy = 1;
        repeat (3) @(negedge clk);
        chk("rst_stall", bif0.stall, 0);
        chk("rst_flush", bif0.flush, 0);
        chk("rst_redir", bif0.redir_val, 0);
        chk("rst_upd", bif0.bp_upd_val, 0);
        chk("rst_cnt", bif0.mispred_cnt, 0);
        chk("rst_redir_ip", bif0.redir_ip, 0);
        chk("rst_upd_ip", bif0.bp_upd_ip, 0);
        clr = 1;

        // correct prediction, taken
        clr_counts();
        issue(32'h1000, 32'h1004, 32'h2000, 1, 1);
        chk("c_upd_val", bif0.bp_upd_val, 1);
        chk("c_upd_ip", bif0.bp_upd_ip, 32'h1000);
        chk("c_upd_tgt", bif0.bp_upd_target, 32'h2000);
        chk("c_upd_taken", bif0.bp_upd_taken, 1);
        repeat (3) @(negedge clk);
        chk("c_n_upd", n_upd, 1);
        chk("c_n_flush", n_flush, 0);

        // mispredict taken, fetch ack held off 3 cycles
        clr_counts();
        bif0.fe_ack = 0;
        issue(32'h1000, 32'h1004, 32'h3000, 1, 0);
        wait_redir();
        chk("mt_redir_ip", bif0.redir_ip, 32'h3000);
        repeat (3) @(negedge clk);
        bif0.fe_ack = 1;
        @(negedge clk);
        bif0.fe_ack = 0;
        repeat (3) @(negedge clk);
        chk("mt_n_flush", n_flush, 2);
        chk("mt_n_redir", n_redir, 4);
        chk("mt_n_upd", n_upd, 1);
        chk("mt_cnt", bif0.mispred_cnt, 1);

        // mispredict not-taken; fe_ack held high throughout
        bif0.fe_ack = 1;
        issue(32'h1008, 32'h1010, 32'h5000, 0, 0);
        wait_redir();
        chk("mn_redir_ip", bif0.redir_ip, 32'h1010);
        @(negedge clk);
        chk("mn_upd_val", bif0.bp_upd_val, 1);
        chk("mn_upd_taken", bif0.bp_upd_taken, 0);
        chk("mn_upd_ip", bif0.bp_upd_ip, 32'h1008);
        repeat (2) @(negedge clk);
        chk("mn_cnt", bif0.mispred_cnt, 2);
        bif0.fe_ack = 0;

        // predictor back-pressure; a mispredict pulse inside the window is ignored
        bif0.bp_rdy = 0;
        issue(32'h4000, 32'h4004, 32'h4800, 1, 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_stall", bif0.stall, 1);
            chk("bp_hold_upd", bif0.bp_upd_val, 1);
            if (k == 1) begin
                bif0.br_val = 1; bif0.br_correct = 0; bif0.br_ip = 32'h9999;
                bif0.br_fip = 32'h8888;
            end
            if (k == 2) bif0.br_val = 0;
            @(negedge clk);
        end
        bif0.bp_rdy = 1;
        repeat (3) @(negedge clk);
        chk("bp_cnt", bif0.mispred_cnt, 2);
        chk("bp_stall_off", bif0.stall, 0);

        // reset during REDIR
        bif0.fe_ack = 0;
        issue(32'h6000, 32'h6004, 32'h7000, 1, 0);
        wait_redir();
        #3 clr = 0;
        #1;
        chk("ar_stall", bif0.stall, 0);
        chk("ar_flush", bif0.flush, 0);
        chk("ar_redir", bif0.redir_val, 0);
        chk("ar_upd", bif0.bp_upd_val, 0);
        chk("ar_cnt", bif0.mispred_cnt, 0);
        chk("ar_redir_ip", bif0.redir_ip, 0);
        chk("ar_upd_ip", bif0.bp_upd_ip, 0);
        @(negedge clk);
        clr = 1;
        bif0.fe_ack = 1;
        issue(32'h1100, 32'h1104, 32'h1200, 1, 1);
        chk("ar_next_upd", bif0.bp_upd_val, 1);
        chk("ar_next_ip", bif0.bp_upd_ip, 32'h1100);
        chk("ar_next_flush", bif0.flush, 0);
        repeat (3) @(negedge clk);
        bif0.fe_ack = 0;

        // counter saturation on the 4-bit instance (FLUSH_CYC=1)
        n1_flush = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            bif1.br_val = 1;
            @(negedge clk);
            bif1.br_val = 0;
            repeat (3) @(negedge clk);
            if (n == 14) begin
                chk("sat_cnt_15", bif1.mispred_cnt, 15);
                chk("sat_n_flush", n1_flush, 15);
            end
        end
        chk("sat_hold", bif1.mispred_cnt, 15);
        chk("sat_idle", bif1.stall, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
